// File: rtl/regfile_pkg.sv
// Shared constants and clear-FSM state type for the multi-port register file.
package regfile_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} clr_state_e;
endpackage

// File: rtl/regfile_clearctl.sv
// Clear sequencer: walks addresses 1..DEPTH-1 one per cycle, strobing a zero-write.
module regfile_clearctl
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_clr_addr,
  output logic              o_clr_we
);
  localparam logic [ADDR_W-1:0] LAST = '1;

  clr_state_e        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
  logic              r_done, w_done_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Address 0 is hardwired to zero, so the walk starts at 1 and holds at LAST.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_req) begin
          w_state_nxt = CLEAR;
          w_cnt_nxt   = ADDR_W'(1);
        end
      end
      CLEAR: begin
        if (r_cnt == LAST) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + ADDR_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_busy     = (r_state == CLEAR);
  assign o_clr_we   = (r_state == CLEAR);
  assign o_clr_addr = r_cnt;
  assign o_done     = r_done;
endmodule

// File: rtl/regfile_mp.sv
// Two-read/one-write register file, r0 hardwired to zero, with a sequenced clear.
// Define REGFILE_BYPASS_EN to forward same-edge write data onto the read outputs.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] regS,
  input  logic [ADDR_W-1:0] regT,
  input  logic [ADDR_W-1:0] regD,
  input  logic [DATA_W-1:0] regsIn,
  input  logic              registerFileWP,
  input  logic              clearReq,
  output logic [DATA_W-1:0] regsOutA,
  output logic [DATA_W-1:0] regsOutB,
  output logic              clearBusy,
  output logic              clearDone
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_out_a, r_out_b;
  logic [DATA_W-1:0] w_rd_a, w_rd_b;
  logic              w_busy, w_done, w_clr_we, w_we;
  logic [ADDR_W-1:0] w_clr_addr;

  regfile_clearctl #(.ADDR_W(ADDR_W)) u_clearctl (
    .i_clk      (clock),
    .i_rst_n    (reset),
    .i_req      (clearReq),
    .o_busy     (w_busy),
    .o_done     (w_done),
    .o_clr_addr (w_clr_addr),
    .o_clr_we   (w_clr_we)
  );

  // A clear in progress owns the write port; user writes never collide with it.
  assign w_we = !registerFileWP && !w_busy && (regD != '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_we)     r_mem[regD]       <= regsIn;
      if (w_clr_we) r_mem[w_clr_addr] <= '0;
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign w_rd_a = (w_we && (regD == regS)) ? regsIn : r_mem[regS];
  assign w_rd_b = (w_we && (regD == regT)) ? regsIn : r_mem[regT];
`else
  assign w_rd_a = r_mem[regS];
  assign w_rd_b = r_mem[regT];
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_out_a <= '0;
      r_out_b <= '0;
    end else begin
      r_out_a <= w_rd_a;
      r_out_b <= w_rd_b;
    end
  end

  assign regsOutA  = r_out_a;
  assign regsOutB  = r_out_b;
  assign clearBusy = w_busy;
  assign clearDone = w_done;
endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus queues expectations, monitor checks after each edge.
module tb_regfile_mp;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock, reset;
  logic [4:0]  regS, regT, regD;
  logic [31:0] regsIn;
  logic        registerFileWP, clearReq;
  logic [31:0] regsOutA, regsOutB;
  logic        clearBusy, clearDone;

  regfile_mp #(.DATA_W(32), .ADDR_W(5)) dut (
    .clock          (clock),
    .reset          (reset),
    .regS           (regS),
    .regT           (regT),
    .regD           (regD),
    .regsIn         (regsIn),
    .registerFileWP (registerFileWP),
    .clearReq       (clearReq),
    .regsOutA       (regsOutA),
    .regsOutB       (regsOutB),
    .clearBusy      (clearBusy),
    .clearDone      (clearDone)
  );

  typedef struct {
    string       nm;
    int          due;
    bit          ca, cb, cs, cd;
    logic [31:0] a, b;
    logic        busy, done;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] got, logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, want, cyc);
    end
  endfunction

  // Monitor: every entry becomes due after a specific rising edge.
  always @(negedge clock) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.due < cyc) chk({e.nm, "_late"}, 32'(cyc), 32'(e.due));
      if (e.ca) chk({e.nm, "_A"}, regsOutA, e.a);
      if (e.cb) chk({e.nm, "_B"}, regsOutB, e.b);
      if (e.cs) chk({e.nm, "_busy"}, 32'(clearBusy), 32'(e.busy));
      if (e.cd) chk({e.nm, "_done"}, 32'(clearDone), 32'(e.done));
    end
  end

  task automatic drv(input bit wp, input logic [4:0] d, input logic [31:0] din,
                     input logic [4:0] s, input logic [4:0] t, input bit c);
    @(negedge clock);
    registerFileWP = wp;
    regD = d;
    regsIn = din;
    regS = s;
    regT = t;
    clearReq = c;
  endtask

  task automatic push_exp(input string nm, input bit ca, input logic [31:0] a,
                          input bit cb, input logic [31:0] b,
                          input bit cs, input logic busy, input bit cd, input logic done);
    exp_t e;
    e.nm = nm; e.due = cyc + 1;
    e.ca = ca; e.a = a; e.cb = cb; e.b = b;
    e.cs = cs; e.busy = busy; e.cd = cd; e.done = done;
    q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; registerFileWP = 1'b0; clearReq = 1'b0;
    regS = '0; regT = '0; regD = '0; regsIn = '0;

    @(negedge clock);
    push_exp("reset_state", 1, 0, 1, 0, 1, 0, 1, 0);
    @(negedge clock);
    // First edge after reset release must accept a write.
    reset = 1'b1; regD = 5'd1; regsIn = 32'h11; regS = 5'd1;
    push_exp("first_wr", 1, BYP ? 32'h11 : 32'h0, 1, 0, 1, 0, 1, 0);

    drv(0, 5'd7,  32'h05555555, 5'd1, 5'd0, 0);
    push_exp("rd_r1", 1, 32'h11, 0, 0, 0, 0, 0, 0);
    drv(0, 5'd15, 32'h0AAAAAAA, 5'd7, 5'd1, 0);
    push_exp("rd_r7", 1, 32'h05555555, 1, 32'h11, 0, 0, 0, 0);
    drv(1, 5'd3,  32'hDEADBEEF, 5'd7, 5'd15, 0);
    push_exp("rd_r7_r15", 1, 32'h05555555, 1, 32'h0AAAAAAA, 0, 0, 0, 0);
    drv(0, 5'd0,  32'hFFFFFFFF, 5'd3, 5'd15, 0);
    push_exp("wp_blocked", 1, 0, 1, 32'h0AAAAAAA, 0, 0, 0, 0);
    drv(1, 5'd0,  32'h0, 5'd0, 5'd0, 0);
    push_exp("r0_zero", 1, 0, 1, 0, 0, 0, 0, 0);
    drv(0, 5'd5,  32'h12345678, 5'd5, 5'd5, 0);
    push_exp("same_edge_wr", 1, BYP ? 32'h12345678 : 32'h0, 1, BYP ? 32'h12345678 : 32'h0, 0, 0, 0, 0);
    drv(1, 5'd0,  32'h0, 5'd5, 5'd5, 0);
    push_exp("after_wr", 1, 32'h12345678, 1, 32'h12345678, 0, 0, 0, 0);

    for (int i = 1; i < 32; i++) drv(0, 5'(i), 32'h10000000 | 32'(i), 5'd0, 5'd0, 0);
    drv(1, 5'd0, 32'h0, 5'd9, 5'd31, 0);
    push_exp("filled", 1, 32'h10000009, 1, 32'h1000001F, 1, 0, 1, 0);

    // Write and clear request on the same edge: write lands, clear zeroes it later.
    drv(0, 5'd9, 32'h99, 5'd9, 5'd31, 1);
    push_exp("clr_start", 1, BYP ? 32'h99 : 32'h10000009, 1, 32'h1000001F, 1, 1, 1, 0);
    drv(0, 5'd9, 32'hBAD, 5'd9, 5'd31, 0);
    push_exp("clr_wr_ign", 1, 32'h99, 1, 32'h1000001F, 1, 1, 1, 0);
    for (int j = 2; j <= 30; j++) begin
      drv(0, 5'd0, 32'h0, 5'd9, 5'd31, j == 5);
      push_exp("clr_busy", 1, (j <= 9) ? 32'h99 : 32'h0, 1, 32'h1000001F, 1, 1, 1, 0);
    end
    drv(1, 5'd0, 32'h0, 5'd9, 5'd31, 0);
    push_exp("clr_last", 1, 0, 1, 32'h1000001F, 1, 0, 1, 1);
    drv(1, 5'd0, 32'h0, 5'd9, 5'd31, 0);
    push_exp("clr_done_off", 1, 0, 1, 0, 1, 0, 1, 0);
    for (int i = 1; i < 32; i++) begin
      drv(1, 5'd0, 32'h0, 5'(i), 5'(32 - i), 0);
      push_exp("post_clr", 1, 0, 1, 0, 0, 0, 1, 0);
    end

    // Reset in the 10th busy cycle aborts the clear.
    drv(0, 5'd3, 32'h33, 5'd0, 5'd0, 0);
    drv(0, 5'd0, 32'h0, 5'd3, 5'd3, 1);
    push_exp("rc_start", 1, 32'h33, 0, 0, 1, 1, 1, 0);
    for (int j = 1; j <= 9; j++) begin
      drv(0, 5'd0, 32'h0, 5'd3, 5'd3, 0);
      push_exp("rc_busy", 1, (j <= 3) ? 32'h33 : 32'h0, 0, 0, 1, 1, 1, 0);
    end
    @(negedge clock);
    reset = 1'b0;
    regS = 5'd7; regT = 5'd15;
    #1;
    chk("async_rst_busy", 32'(clearBusy), 32'h0);
    chk("async_rst_A", regsOutA, 32'h0);
    push_exp("rst_mid", 1, 0, 1, 0, 1, 0, 1, 0);
    @(negedge clock);
    push_exp("rst_hold", 1, 0, 1, 0, 1, 0, 1, 0);
    @(negedge clock);
    reset = 1'b1; registerFileWP = 1'b0; regD = 5'd2; regsIn = 32'h00000042;
    regS = 5'd2; regT = 5'd3;
    push_exp("rst_first_wr", 1, BYP ? 32'h42 : 32'h0, 1, 0, 1, 0, 1, 0);
    drv(1, 5'd0, 32'h0, 5'd2, 5'd15, 0);
    push_exp("rst_readback", 1, 32'h00000042, 1, 0, 1, 0, 1, 0);
    drv(1, 5'd0, 32'h0, 5'd2, 5'd7, 0);
    push_exp("rst_no_done", 1, 32'h00000042, 1, 0, 1, 0, 1, 0);

    @(negedge clock);
    @(negedge clock);
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have port clock  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port regS  input  ADDR_W  read address, port A.
REQ-006 SHALL have port regT  input  ADDR_W  read address, port B.
REQ-007 SHALL have port regD  input  ADDR_W  write address.
REQ-008 SHALL have port regsIn  input  DATA_W  write data.
REQ-009 SHALL have port registerFileWP  input  1  write protect; 0 = write enabled, 1 = write blocked.
REQ-010 SHALL have port clearReq  input  1  single-cycle request to zero the whole file.
REQ-011 SHALL have port regsOutA  output  DATA_W  registered read data for regS.
REQ-012 SHALL have port regsOutB  output  DATA_W  registered read data for regT.
REQ-013 SHALL have port clearBusy  output  1  high while clear sequence runs.
REQ-014 SHALL have port clearDone  output  1  one-cycle pulse when clear sequence completes.

Function
REQ-015 Write SHALL occur on rising edge when registerFileWP=0, clearBusy=0 and regD!=0: reg[regD] <= regsIn.
REQ-016 Register 0 SHALL always read 0; writes to address 0 SHALL be discarded.
REQ-017 Reads SHALL be registered: regsOutA/B update on each rising edge with contents of reg[regS]/reg[regT]; latency one cycle.
REQ-018 Both read ports SHALL be independent; regS==regT SHALL return identical data on both outputs.
REQ-019 Clear FSM SHALL have states IDLE and CLEAR.
REQ-020 IDLE: clearReq=1 SHALL move to CLEAR on next edge, loading counter to 1; clearReq in CLEAR SHALL be ignored.
REQ-021 CLEAR: each edge SHALL zero reg[counter] and increment counter; clearBusy=1 throughout.
REQ-022 CLEAR with counter==DEPTH-1: SHALL zero that register, return to IDLE, pulse clearDone for exactly one cycle; total clearBusy duration DEPTH-1 cycles.
REQ-023 During CLEAR, normal writes SHALL be ignored regardless of registerFileWP; reads SHALL continue, returning current (partially cleared) contents.
REQ-024 Counter SHALL be ADDR_W bits and SHALL not wrap past DEPTH-1.
REQ-025 Simultaneous clearReq and enabled write in IDLE: the write SHALL complete on that edge; clearing starts next edge and later zeroes it.

Reset
REQ-026 reset=0 SHALL asynchronously zero all registers, regsOutA, regsOutB, counter, and force IDLE, clearBusy=0, clearDone=0.
REQ-027 Reset asserted mid-CLEAR SHALL abort the sequence with no clearDone pulse.
REQ-028 After reset deassertion, first write SHALL be accepted on the first rising edge.

Configuration
REQ-029 Macro REGFILE_BYPASS_EN defined: when an enabled write targets regD equal to regS (or regT), nonzero, the same edge SHALL load regsIn into regsOutA (or regsOutB).
REQ-030 REGFILE_BYPASS_EN undefined: the same case SHALL load the pre-write value; new value visible one edge later.

Structure
REQ-031 Package regfile_pkg SHALL hold default DATA_W/ADDR_W constants and the clear-FSM state typedef (IDLE, CLEAR).
REQ-032 Clear FSM and counter SHALL be a sub-module regfile_clearctl providing busy, done, clear address and clear-write strobe.
REQ-033 Storage array and read/bypass logic SHALL remain in regfile_mp.

Verification
REQ-034 Write 32'h05555555 to r7, 32'h0AAAAAAA to r15 (WP=0), then WP=1, regS=7, regT=15 -> after one edge regsOutA=32'h05555555, regsOutB=32'h0AAAAAAA.
REQ-035 WP=1, regD=3, regsIn=32'hDEADBEEF, then read r3 -> regsOutA=0; write to r0 value 32'hFFFFFFFF -> read r0 = 0.
REQ-036 Write r5=32'h12345678 with regS=5 same edge -> regsOutA=32'h12345678 with REGFILE_BYPASS_EN, old value 0 without it.
REQ-037 Fill r1..r31 nonzero, pulse clearReq -> clearBusy high 31 cycles, clearDone one pulse, all reads 0; WP=0 write to r9 during CLEAR -> r9 reads 0.
REQ-038 Reset asserted on 10th CLEAR cycle -> all outputs 0, clearBusy=0, no clearDone; next write r2=32'h00000042 reads back 32'h00000042.
